led_frame_sequencer: RTL and testbench

Frame-level controller for the LED breathing datapath. It walks the strip address range once per frame and drives `addr`, `count_time` and `color_flag` into the combinational brightness/colour block. It registers the returned 24-bit colour and hands each pixel to the downstream serial LED driver over a valid/ready handshake. After each frame it inserts the strip latch gap, then advances the breathing phase and, on phase wrap, the colour scheme.

---
 rtl/led_frame_sequencer_pkg.sv | 19 +
 rtl/cycle_timer.sv | 29 ++
 rtl/led_frame_sequencer.sv | 121 ++++++++++++
 tb/tb_led_frame_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_frame_sequencer_pkg.sv
// Shared widths and FSM state encoding for the LED frame sequencer.
package led_frame_sequencer_pkg;

    localparam int ADDR_W  = 6;
    localparam int PHASE_W = 9;
    localparam int FLAG_W  = 3;
    localparam int COLOR_W = 24;

    localparam logic [PHASE_W-1:0] PHASE_MAX = 9'd511;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        LATCH,
        UPDATE
    } state_t;

endpackage

// File: rtl/cycle_timer.sv
// Up-counter that restarts from zero on start and flags the last cycle of a
// CYCLES-long interval while run is held.
module cycle_timer #(
    parameter int CYCLES = 3000,
    parameter int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic done
);

    logic [CNT_W-1:0] count;

    assign done = (count == CNT_W'(CYCLES - 1));

    // Saturates at the terminal value so a late consumer still sees done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (run && !done) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/led_frame_sequencer.sv
// Walks the strip once per frame, streams registered pixels over valid/ready,
// inserts the latch gap and advances the breathing phase / colour scheme.
module led_frame_sequencer
    import led_frame_sequencer_pkg::*;
#(
    parameter int NUM_LEDS        = 60,
    parameter int LATCH_CYCLES    = 3000,
    parameter int FRAMES_PER_STEP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [COLOR_W-1:0] color_in,
    output logic [ADDR_W-1:0]  addr,
    output logic [PHASE_W-1:0] count_time,
    output logic [FLAG_W-1:0]  color_flag,
    output logic               pix_valid,
    output logic [COLOR_W-1:0] pix_data,
    input  logic               pix_ready,
    output logic               frame_done,
    output logic               busy
);

    localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_LEDS - 1);
    localparam logic [FC_W-1:0]   LAST_FRAME = FC_W'(FRAMES_PER_STEP - 1);

    state_t          state;
    logic [FC_W-1:0] frame_cnt;
    logic            last_handshake;
    logic            latch_done;

    assign last_handshake = (state == SEND) && pix_ready && (addr == LAST_ADDR);

    cycle_timer #(
        .CYCLES(LATCH_CYCLES)
    ) u_latch_timer (
        .clk  (clk),
        .rst  (rst),
        .start(last_handshake),
        .run  (state == LATCH),
        .done (latch_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            count_time <= '0;
            color_flag <= '0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= FETCH;
                        addr  <= '0;
                        busy  <= 1'b1;
                    end
                end

                FETCH: begin
                    pix_data  <= color_in;
                    pix_valid <= 1'b1;
                    state     <= SEND;
                end

                SEND: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (addr == LAST_ADDR) begin
                            state <= LATCH;
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= FETCH;
                        end
                    end
                end

                LATCH: begin
                    if (latch_done) begin
                        state      <= UPDATE;
                        frame_done <= 1'b1;
                    end
                end

                // Phase and scheme only move here, so they are frozen for a whole frame.
                UPDATE: begin
                    if (frame_cnt == LAST_FRAME) begin
                        frame_cnt  <= '0;
                        count_time <= count_time + 1'b1;
                        if (count_time == PHASE_MAX) begin
                            color_flag <= color_flag + 1'b1;
                        end
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                    if (enable) begin
                        state <= FETCH;
                        addr  <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    pix_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench for led_frame_sequencer: small-strip instance for frame and
// handshake behaviour, tiny instance to reach phase and colour-scheme wrap.
module tb_led_frame_sequencer;

    localparam int N   = 4;
    localparam int L   = 5;
    localparam int FPS = 2;
    localparam logic [5:0] LAST = 6'(N - 1);

    logic        clk;
    logic        rst;
    logic        enable;
    logic [23:0] color_in;
    logic [5:0]  addr;
    logic [8:0]  count_time;
    logic [2:0]  color_flag;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;
    logic        frame_done;
    logic        busy;

    logic        enable_f;
    logic [23:0] color_in_f;
    logic [5:0]  addr_f;
    logic [8:0]  count_time_f;
    logic [2:0]  color_flag_f;
    logic        pix_valid_f;
    logic [23:0] pix_data_f;
    logic        pix_ready_f;
    logic        frame_done_f;
    logic        busy_f;

    int tests_run = 0;
    int failures  = 0;
    int frames_seen = 0;
    bit prev_fd = 0;
    logic [23:0] exp_q[$];

    assign color_in    = {2'b00, addr, 16'h00AA};
    assign color_in_f  = {2'b00, addr_f, 16'h00AA};
    assign pix_ready_f = 1'b1;

    led_frame_sequencer #(
        .NUM_LEDS(N), .LATCH_CYCLES(L), .FRAMES_PER_STEP(FPS)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .color_in(color_in),
        .addr(addr), .count_time(count_time), .color_flag(color_flag),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .frame_done(frame_done), .busy(busy)
    );

    led_frame_sequencer #(
        .NUM_LEDS(1), .LATCH_CYCLES(1), .FRAMES_PER_STEP(1)
    ) dut_fast (
        .clk(clk), .rst(rst), .enable(enable_f), .color_in(color_in_f),
        .addr(addr_f), .count_time(count_time_f), .color_flag(color_flag_f),
        .pix_valid(pix_valid_f), .pix_data(pix_data_f), .pix_ready(pix_ready_f),
        .frame_done(frame_done_f), .busy(busy_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Pops one expected pixel per handshake and tracks the phase model per frame.
    always @(negedge clk) begin
        if (rst) begin
            frames_seen = 0;
            prev_fd     = 1'b0;
        end else begin
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) checkOutput("sb_underflow", exp_q.size(), 1);
                else                   checkOutput("pix_data", pix_data, exp_q.pop_front());
            end
            if (prev_fd) begin
                frames_seen++;
                checkOutput("count_time", count_time, (frames_seen / FPS) % 512);
                checkOutput("color_flag", color_flag, (frames_seen / (FPS * 512)) % 8);
            end
            prev_fd = frame_done;
        end
    end

    task automatic applyStimulus(input int n_frames, input int stall_addr, input int stall_len, input int exp_busy);
        int busy_cycles = 0;
        int hs = 0;
        int fd = 0;
        int gap = 0;
        int gap_valid = 0;
        int stall_cnt = 0;
        int iter = 0;
        bit in_gap = 0;
        logic [23:0] stall_exp;
        stall_exp = {2'b00, 6'(stall_addr), 16'h00AA};
        for (int f = 0; f < n_frames; f++)
            for (int a = 0; a < N; a++)
                exp_q.push_back({2'b00, 6'(a), 16'h00AA});
        enable    = 1'b1;
        pix_ready = 1'b1;
        do begin
            @(posedge clk);
            #1;
            enable    = (fd < n_frames - 1);
            pix_ready = !((int'(addr) == stall_addr) && (stall_cnt < stall_len));
            @(negedge clk);
            iter++;
            if (busy) busy_cycles++;
            if (!pix_ready && (pix_valid || stall_cnt > 0)) begin
                checkOutput("stall_valid", pix_valid, 1);
                checkOutput("stall_data", pix_data, stall_exp);
                stall_cnt++;
            end
            if (pix_valid && pix_ready) begin
                hs++;
                if (addr == LAST) in_gap = 1'b1;
            end else if (in_gap) begin
                if (frame_done) in_gap = 1'b0;
                else begin
                    gap++;
                    if (pix_valid) gap_valid++;
                end
            end
            if (frame_done) fd++;
        end while (busy && iter < 400);
        if (iter >= 400) checkOutput("frame_timeout", busy, 0);
        pix_ready = 1'b1;
        checkOutput("busy_cycles", busy_cycles, exp_busy);
        checkOutput("handshakes", hs, N * n_frames);
        checkOutput("frame_done_pulses", fd, n_frames);
        checkOutput("latch_gap", gap, L * n_frames);
        checkOutput("gap_valid", gap_valid, 0);
        checkOutput("stall_cycles", stall_cnt, stall_len);
        checkOutput("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        int iter;
        int k;
        bit pfd;
        rst       = 1'b1;
        enable    = 1'b0;
        pix_ready = 1'b0;
        enable_f  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_addr", addr, 0);
        checkOutput("rst_count_time", count_time, 0);
        checkOutput("rst_color_flag", color_flag, 0);
        checkOutput("rst_pix_valid", pix_valid, 0);
        checkOutput("rst_pix_data", pix_data, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_busy", busy, 0);

        applyStimulus(1, -1, 0, 2 * N + L + 1);
        applyStimulus(1, 2, 3, 2 * N + L + 1 + 3);
        applyStimulus(2, -1, 0, 2 * (2 * N + L + 1));

        // Stall on pixel 2, then reset while it is still offered.
        exp_q.push_back({2'b00, 6'd0, 16'h00AA});
        exp_q.push_back({2'b00, 6'd1, 16'h00AA});
        enable    = 1'b1;
        pix_ready = 1'b1;
        iter      = 0;
        do begin
            @(posedge clk);
            #1;
            enable    = 1'b0;
            pix_ready = (addr != 6'd2);
            @(negedge clk);
            iter++;
        end while (!(pix_valid && addr == 6'd2) && iter < 50);
        if (iter >= 50) checkOutput("send_timeout", pix_valid, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_pix_valid", pix_valid, 0);
        checkOutput("async_addr", addr, 0);
        checkOutput("async_count_time", count_time, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("sb_after_reset", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        pix_ready = 1'b1;
        applyStimulus(1, -1, 0, 2 * N + L + 1);

        // One-pixel strip, one-cycle gap: 4 clocks per frame reaches both wraps.
        @(posedge clk);
        #1;
        enable_f = 1'b1;
        k    = 0;
        pfd  = 1'b0;
        iter = 0;
        while (k < 4096 && iter < 20000) begin
            @(negedge clk);
            iter++;
            if (pfd) begin
                k++;
                if (k == 511 || k == 512 || k == 4095 || k == 4096) begin
                    checkOutput("fast_count_time", count_time_f, k % 512);
                    checkOutput("fast_color_flag", color_flag_f, (k / 512) % 8);
                end
            end
            pfd = frame_done_f;
        end
        enable_f = 1'b0;
        if (k < 4096) checkOutput("fast_timeout", k, 4096);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
